// File: rtl/pll_dyn_pkg.sv
// Shared types for the HDMI PLL dynamic loop-filter controller: filter settings,
// characterized fallback table and FSM state encoding.
package pll_dyn_pkg;

  typedef struct packed {
    logic [5:0] icp;
    logic [2:0] res;
    logic [1:0] cap;
  } lf_cfg_t;

  // Ordered nominal -> most damped; later entries trade bandwidth for lock margin.
  localparam lf_cfg_t LF_TABLE [0:3] = '{
    '{icp: 6'h10, res: 3'd2, cap: 2'd1},
    '{icp: 6'h0c, res: 3'd3, cap: 2'd1},
    '{icp: 6'h08, res: 3'd4, cap: 2'd2},
    '{icp: 6'h04, res: 3'd6, cap: 2'd3}
  };

  typedef enum logic [2:0] {
    S_RST,
    S_WAIT,
    S_STABLE,
    S_LOCKED,
    S_FAIL
  } pll_dyn_state_t;

endpackage

// File: rtl/pll_dyn_ctrl_if.sv
// PLL-side and status signals of the dynamic PLL controller.
// master = controller, slave = PLL / video reset tree.
interface pll_dyn_ctrl_if;
  logic       reprog;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic [1:0] lpfcap;
  logic       locked;
  logic       fail;
  logic [1:0] try_idx;
  logic [7:0] loss_cnt;

  modport master (
    input  reprog, pll_lock,
    output pll_reset, icpsel, lpfres, lpfcap, locked, fail, try_idx, loss_cnt
  );

  modport slave (
    output reprog, pll_lock,
    input  pll_reset, icpsel, lpfres, lpfcap, locked, fail, try_idx, loss_cnt
  );
endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the board clock domain.
module pll_lock_sync (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_pipe;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_pipe <= '0;
    else         sync_pipe <= {sync_pipe[0], din};
  end

  assign dout = sync_pipe[1];

endmodule

// File: rtl/pll_dyn_ctrl.sv
// HDMI PLL loop-filter sequencer and lock supervisor, clocked by the free-running board clock.
// Optional PLL_LOSS_COUNT_EN builds the saturating lock-loss counter; otherwise loss_cnt is 0.
module pll_dyn_ctrl
  import pll_dyn_pkg::*;
#(
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_TRY      = 4
) (
  input  logic           clk,
  input  logic           resetn,
  pll_dyn_ctrl_if.master bus
);

  localparam int CW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SW = $clog2(LOCK_STABLE) + 1;
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [1:0]    TRY_LAST = 2'(MAX_TRY - 1);

  logic lock_s;

  pll_lock_sync u_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (bus.pll_lock),
    .dout   (lock_s)
  );

  pll_dyn_state_t state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [SW-1:0]  stb, stb_nxt;
  logic [1:0]     try_q, try_nxt;
  lf_cfg_t        cfg_q;
  logic           rst_q, locked_q, fail_q;
  logic           timeout, expire;

  assign timeout = (cnt == TMO_LAST);

  // cnt is shared: RST hold length, then the lock budget across WAIT/STABLE bounces.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    stb_nxt   = stb;
    try_nxt   = try_q;
    expire    = 1'b0;
    if (bus.reprog) begin
      state_nxt = S_RST;
      cnt_nxt   = '0;
      try_nxt   = '0;
    end else begin
      case (state)
        S_RST: begin
          if (cnt == RST_LAST) begin
            state_nxt = S_WAIT;
            cnt_nxt   = '0;
          end
        end
        S_WAIT: begin
          if (timeout) expire = 1'b1;
          else if (lock_s) begin
            state_nxt = S_STABLE;
            stb_nxt   = '0;
          end
        end
        S_STABLE: begin
          if (lock_s && stb == STB_LAST) state_nxt = S_LOCKED;
          else if (timeout) expire = 1'b1;
          else if (!lock_s) begin
            state_nxt = S_WAIT;
            stb_nxt   = '0;
          end else stb_nxt = stb + 1'b1;
        end
        S_LOCKED: begin
          cnt_nxt = cnt;
          if (!lock_s) begin
            state_nxt = S_RST;
            cnt_nxt   = '0;
          end
        end
        S_FAIL:  cnt_nxt = cnt;
        default: state_nxt = S_RST;
      endcase
      if (expire) begin
        if (try_q != TRY_LAST) begin
          try_nxt   = try_q + 1'b1;
          state_nxt = S_RST;
          cnt_nxt   = '0;
        end else state_nxt = S_FAIL;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_RST;
      cnt      <= '0;
      stb      <= '0;
      try_q    <= '0;
      cfg_q    <= LF_TABLE[0];
      rst_q    <= 1'b1;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      stb      <= stb_nxt;
      try_q    <= try_nxt;
      rst_q    <= (state_nxt == S_RST) || (state_nxt == S_FAIL);
      locked_q <= (state_nxt == S_LOCKED);
      fail_q   <= (state_nxt == S_FAIL);
      // Filter inputs only move on edges that leave the PLL held in reset.
      if (state_nxt == S_RST) cfg_q <= LF_TABLE[try_nxt];
    end
  end

`ifdef PLL_LOSS_COUNT_EN
  logic       loss_inc;
  logic [7:0] loss_q;

  assign loss_inc = (state == S_LOCKED) && !lock_s && !bus.reprog;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                         loss_q <= '0;
    else if (loss_inc && loss_q != 8'hFF) loss_q <= loss_q + 1'b1;
  end

  assign bus.loss_cnt = loss_q;
`else
  assign bus.loss_cnt = 8'd0;
`endif

  assign bus.pll_reset = rst_q;
  assign bus.icpsel    = cfg_q.icp;
  assign bus.lpfres    = cfg_q.res;
  assign bus.lpfcap    = cfg_q.cap;
  assign bus.locked    = locked_q;
  assign bus.fail      = fail_q;
  assign bus.try_idx   = try_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl with short timing parameters and hand-computed expectations.
module tb_pll_dyn_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [10:0] exp_lf [4] = '{11'h209, 11'h18D, 11'h112, 11'h09B};

`ifdef PLL_LOSS_COUNT_EN
  localparam int LOSS1 = 1;
  localparam int LOSS2 = 2;
`else
  localparam int LOSS1 = 0;
  localparam int LOSS2 = 0;
`endif

  pll_dyn_ctrl_if bus();

  pll_dyn_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .LOCK_STABLE  (8),
    .MAX_TRY      (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rst(input logic lvl, input string tag);
    int n = 0;
    while (bus.pll_reset !== lvl && n < 200) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(bus.pll_reset), 32'(lvl));
  endtask

  function automatic logic [10:0] lf();
    return {bus.icpsel, bus.lpfres, bus.lpfcap};
  endfunction

  initial begin
    bus.reprog   = 1'b0;
    bus.pll_lock = 1'b0;
    tick(3);
    chk("rst_pll_reset", 32'(bus.pll_reset), 1);
    chk("rst_lf",        32'(lf()), 32'(exp_lf[0]));
    chk("rst_locked",    32'(bus.locked), 0);
    chk("rst_fail",      32'(bus.fail), 0);
    chk("rst_try",       32'(bus.try_idx), 0);
    chk("rst_loss",      32'(bus.loss_cnt), 0);

    // Basic lock: PLL locks 10 cycles after reset release
    resetn = 1'b1;
    tick(3);
    chk("pulse_hi", 32'(bus.pll_reset), 1);
    tick(1);
    chk("pulse_lo", 32'(bus.pll_reset), 0);
    tick(10);
    bus.pll_lock = 1'b1;
    tick(10);
    chk("lock_pre", 32'(bus.locked), 0);
    tick(1);
    chk("lock_rise", 32'(bus.locked), 1);
    chk("lock_try",  32'(bus.try_idx), 0);
    chk("lock_lf",   32'(lf()), 32'(exp_lf[0]));

    // Lock loss: relock with same setting
    bus.pll_lock = 1'b0;
    tick(2);
    chk("loss_hold", 32'(bus.locked), 1);
    tick(1);
    chk("loss_locked", 32'(bus.locked), 0);
    chk("loss_rst",    32'(bus.pll_reset), 1);
    tick(3);
    chk("loss_rst_hi", 32'(bus.pll_reset), 1);
    tick(1);
    chk("loss_rst_lo", 32'(bus.pll_reset), 0);
    chk("loss_try",    32'(bus.try_idx), 0);
    chk("loss_cnt1",   32'(bus.loss_cnt), LOSS1);

    // Glitchy lock: 5 high, 3 low, then steady
    tick(2);
    bus.pll_lock = 1'b1;
    tick(5);
    bus.pll_lock = 1'b0;
    chk("gl_locked_a", 32'(bus.locked), 0);
    tick(3);
    bus.pll_lock = 1'b1;
    chk("gl_locked_b", 32'(bus.locked), 0);
    chk("gl_no_rst_b", 32'(bus.pll_reset), 0);
    tick(10);
    chk("gl_pre",    32'(bus.locked), 0);
    chk("gl_no_rst", 32'(bus.pll_reset), 0);
    tick(1);
    chk("gl_rise", 32'(bus.locked), 1);

    // Lock dropped for good: walk the table to FAIL
    bus.pll_lock = 1'b0;
    tick(3);
    chk("to_rst",  32'(bus.pll_reset), 1);
    chk("to_try0", 32'(bus.try_idx), 0);
    chk("to_lf0",  32'(lf()), 32'(exp_lf[0]));
    wait_rst(1'b0, "to_wait0");
    wait_rst(1'b1, "to_rst1");
    chk("to_try1", 32'(bus.try_idx), 1);
    chk("to_lf1",  32'(lf()), 32'(exp_lf[1]));
    wait_rst(1'b0, "to_wait1");
    tick(31);
    chk("to_edge_pre", 32'(bus.pll_reset), 0);
    tick(1);
    chk("to_edge_rst", 32'(bus.pll_reset), 1);
    chk("to_try2",     32'(bus.try_idx), 2);
    chk("to_lf2",      32'(lf()), 32'(exp_lf[2]));
    wait_rst(1'b0, "to_wait2");
    wait_rst(1'b1, "to_rst3");
    chk("to_try3", 32'(bus.try_idx), 3);
    chk("to_lf3",  32'(lf()), 32'(exp_lf[3]));
    wait_rst(1'b0, "to_wait3");
    tick(31);
    chk("fail_pre", 32'(bus.fail), 0);
    tick(1);
    chk("fail_set",    32'(bus.fail), 1);
    chk("fail_rst",    32'(bus.pll_reset), 1);
    chk("fail_locked", 32'(bus.locked), 0);
    chk("fail_try",    32'(bus.try_idx), 3);
    chk("fail_loss",   32'(bus.loss_cnt), LOSS2);
    tick(5);
    chk("fail_held", 32'(bus.fail), 1);

    // reprog out of FAIL
    bus.reprog = 1'b1;
    tick(1);
    bus.reprog = 1'b0;
    chk("rp_fail", 32'(bus.fail), 0);
    chk("rp_try",  32'(bus.try_idx), 0);
    chk("rp_rst",  32'(bus.pll_reset), 1);
    chk("rp_lf",   32'(lf()), 32'(exp_lf[0]));
    chk("rp_loss", 32'(bus.loss_cnt), LOSS2);

    // reprog coinciding with the try 2 timeout
    wait_rst(1'b0, "rt_wait0");
    wait_rst(1'b1, "rt_rst1");
    wait_rst(1'b0, "rt_wait1");
    wait_rst(1'b1, "rt_rst2");
    chk("rt_try2", 32'(bus.try_idx), 2);
    wait_rst(1'b0, "rt_wait2");
    tick(31);
    bus.reprog = 1'b1;
    tick(1);
    bus.reprog = 1'b0;
    chk("rt_try",  32'(bus.try_idx), 0);
    chk("rt_rst",  32'(bus.pll_reset), 1);
    chk("rt_fail", 32'(bus.fail), 0);
    chk("rt_lf",   32'(lf()), 32'(exp_lf[0]));
    tick(3);
    chk("rt_rst_hi", 32'(bus.pll_reset), 1);
    tick(1);
    chk("rt_rst_lo", 32'(bus.pll_reset), 0);

    // Asynchronous reset mid-WAIT at try 1
    wait_rst(1'b1, "ar_rst1");
    wait_rst(1'b0, "ar_wait1");
    chk("ar_try1", 32'(bus.try_idx), 1);
    tick(5);
    #2 resetn = 1'b0;
    #1;
    chk("ar_rst",    32'(bus.pll_reset), 1);
    chk("ar_try",    32'(bus.try_idx), 0);
    chk("ar_locked", 32'(bus.locked), 0);
    chk("ar_lf",     32'(lf()), 32'(exp_lf[0]));
    chk("ar_loss",   32'(bus.loss_cnt), 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    tick(3);
    chk("ar_pulse_hi", 32'(bus.pll_reset), 1);
    tick(1);
    chk("ar_pulse_lo", 32'(bus.pll_reset), 0);
    bus.pll_lock = 1'b1;
    tick(10);
    chk("ar_lock_pre", 32'(bus.locked), 0);
    tick(1);
    chk("ar_lock", 32'(bus.locked), 1);
    chk("ar_try0", 32'(bus.try_idx), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
